// File: rtl/platform_pkg.sv
// Shared stacked-platform geometry. The drawer and the collision reader both
// derive every coordinate from here so the two layouts cannot diverge.
package platform_pkg;

  localparam int SCREEN_WIDTH    = 1024;
  localparam int SCREEN_HEIGHT   = 768;
  localparam int PLATFORM_WIDTH  = 256;
  localparam int PLATFORM_HEIGHT = 10;
  localparam int N_PLATFORMS     = 10;
  localparam int SCALE           = 2;
  localparam int PLAYER_W        = 32;

  localparam int S_W = PLATFORM_WIDTH * SCALE;
  localparam int S_H = PLATFORM_HEIGHT * SCALE;
  localparam int X0  = (SCREEN_WIDTH - S_W) / 2;
  localparam int X1  = X0 + S_W - 1;
  localparam int GAP = (SCREEN_HEIGHT - N_PLATFORMS * S_H) / (N_PLATFORMS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } scan_state_t;

  // Top row of platform i; index 0 is the bottom platform.
  function automatic logic [11:0] y_top(input logic [3:0] i);
    int ii;
    int t;
    ii = int'(i);
    t  = SCREEN_HEIGHT - S_H - ii * (S_H + GAP);
    return t[11:0];
  endfunction

endpackage

// File: rtl/platform_collision.sv
// Per-frame landing/standing query: scans platforms top-down, one per cycle,
// and reports the highest platform the player's feet cross this frame.
module platform_collision
  import platform_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] player_x,
  input  logic [11:0] feet_y_cur,
  input  logic [11:0] feet_y_nxt,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [3:0]  plat_idx,
  output logic [11:0] land_y
);

  localparam logic [3:0]  IDX_TOP  = 4'(N_PLATFORMS - 1);
  localparam logic [12:0] X0_13    = 13'(X0);
  localparam logic [11:0] X1_12    = 12'(X1);
  localparam logic [12:0] PW_M1_13 = 13'(PLAYER_W - 1);

  scan_state_t state, state_nxt;

  logic [3:0]  idx;
  logic [11:0] px_q;
  logic [11:0] cur_q;
  logic [11:0] nxt_q;

  logic [12:0] right_edge;
  logic        overlap;
  logic [11:0] cand_top;
  logic        plat_hit;

  // Right edge is formed one bit wider so a player near x=4095 cannot wrap
  // around and appear to overlap the platforms.
  assign right_edge = {1'b0, px_q} + PW_M1_13;
  assign overlap    = (right_edge >= X0_13) && (px_q <= X1_12);
  assign cand_top   = y_top(idx);
  assign plat_hit   = overlap && (cur_q <= cand_top) && (nxt_q >= cand_top);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (plat_hit || (idx == 4'd0)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      px_q     <= '0;
      cur_q    <= '0;
      nxt_q    <= '0;
      hit      <= 1'b0;
      plat_idx <= '0;
      land_y   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            px_q     <= player_x;
            cur_q    <= feet_y_cur;
            nxt_q    <= feet_y_nxt;
            idx      <= IDX_TOP;
            hit      <= 1'b0;
            plat_idx <= '0;
            land_y   <= '0;
          end
        end
        ST_SCAN: begin
          if (plat_hit) begin
            hit      <= 1'b1;
            plat_idx <= idx;
            land_y   <= cand_top;
          end else if (idx == 4'd0) begin
            hit      <= 1'b0;
            plat_idx <= '0;
            land_y   <= '0;
          end else begin
            idx <= idx - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_platform_collision.sv
// Randomized self-checking bench for platform_collision: a behavioural model
// predicts busy/done/result every cycle, plus directed landing/edge cases.
module tb_platform_collision;

  localparam int SCW = 1024;
  localparam int SCH = 768;
  localparam int PW  = 256;
  localparam int PH  = 10;
  localparam int NP  = 10;
  localparam int SC  = 2;
  localparam int PLW = 32;

  typedef struct {
    bit hit;
    int idx;
    int land;
    int lat;
  } ref_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] player_x;
  logic [11:0] feet_y_cur;
  logic [11:0] feet_y_nxt;
  logic        busy;
  logic        done;
  logic        hit;
  logic [3:0]  plat_idx;
  logic [11:0] land_y;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  int   m_left = 0;
  bit   m_done = 1'b0;
  bit   m_hit  = 1'b0;
  int   m_idx  = 0;
  int   m_land = 0;
  ref_t pend;

  platform_collision dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .player_x   (player_x),
    .feet_y_cur (feet_y_cur),
    .feet_y_nxt (feet_y_nxt),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .plat_idx   (plat_idx),
    .land_y     (land_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Whole-frame answer straight from the layout equations: walk platforms from
  // the top and take the first one whose top row the feet reach.
  function automatic ref_t compute_ref(input int px, input int cur, input int nxt);
    ref_t r;
    int sw, sh, x0, x1, gap, top;
    sw  = PW * SC;
    sh  = PH * SC;
    x0  = (SCW - sw) / 2;
    x1  = x0 + sw - 1;
    gap = (SCH - NP * sh) / (NP - 1);
    r   = '{hit: 1'b0, idx: 0, land: 0, lat: NP + 1};
    if ((px + PLW - 1 >= x0) && (px <= x1)) begin
      for (int i = NP - 1; i >= 0; i--) begin
        top = SCH - sh - i * (sh + gap);
        if ((cur <= top) && (nxt >= top)) begin
          r.hit  = 1'b1;
          r.idx  = i;
          r.land = top;
          r.lat  = NP - i + 1;
          return r;
        end
      end
    end
    return r;
  endfunction

  // Timing model: an accepted start predicts done exactly lat cycles later.
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hit  <= 1'b0;
      m_idx  <= 0;
      m_land <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_hit  <= pend.hit;
        m_idx  <= pend.idx;
        m_land <= pend.land;
      end
    end else if (start) begin
      pend   <= compute_ref(int'(player_x), int'(feet_y_cur), int'(feet_y_nxt));
      m_left <= compute_ref(int'(player_x), int'(feet_y_cur), int'(feet_y_nxt)).lat - 1;
      m_hit  <= 1'b0;
      m_idx  <= 0;
      m_land <= 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("cyc busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      check("cyc done", {31'd0, done}, {31'd0, m_done});
      check("cyc hit", {31'd0, hit}, {31'd0, m_hit});
      check("cyc plat_idx", {28'd0, plat_idx}, m_idx);
      check("cyc land_y", {20'd0, land_y}, m_land);
    end
  end

  task automatic scramble_inputs();
    player_x   = 12'($urandom);
    feet_y_cur = 12'($urandom);
    feet_y_nxt = 12'($urandom);
  endtask

  task automatic query(input int px, input int cur, input int nxt, input bit eh,
                       input int ei, input int el, input int elat, input string tag);
    int cyc;
    bit got;
    @(posedge clk);
    #2;
    player_x   = 12'(px);
    feet_y_cur = 12'(cur);
    feet_y_nxt = 12'(nxt);
    start      = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    scramble_inputs();
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got = 1'b1;
    end
    check({tag, " done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({tag, " latency"}, cyc, elat);
      check({tag, " hit"}, {31'd0, hit}, {31'd0, eh});
      check({tag, " plat_idx"}, {28'd0, plat_idx}, ei);
      check({tag, " land_y"}, {20'd0, land_y}, el);
    end
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ref_t r;
    int   n;
    int   px, cur, nxt, top;

    rst        = 1'b1;
    start      = 1'b0;
    player_x   = '0;
    feet_y_cur = '0;
    feet_y_nxt = '0;

    // Pin the model against hand-computed layout values.
    r = compute_ref(300, 740, 750);
    check("model bottom", {r.hit, 3'd0, 4'(r.idx), 12'(r.land), 12'(r.lat)},
          {1'b1, 3'd0, 4'd0, 12'd748, 12'd11});
    r = compute_ref(500, 582, 582);
    check("model stand2", {r.hit, 3'd0, 4'(r.idx), 12'(r.land), 12'(r.lat)},
          {1'b1, 3'd0, 4'd2, 12'd582, 12'd9});
    r = compute_ref(224, 740, 750);
    check("model edge224", {31'd0, r.hit}, 32'd0);
    r = compute_ref(10, 0, 4000);
    check("model outside", {31'd0, r.hit}, 32'd0);

    @(posedge clk);
    armed = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", {hit, plat_idx, land_y}, 32'd0);

    query(300, 740, 750, 1'b1, 0, 748, 11, "land bottom");
    query(300, 660, 670, 1'b1, 1, 665, 10, "land plat1");
    query(500, 582, 582, 1'b1, 2, 582, 9, "stand plat2");
    query(100, 740, 750, 1'b0, 0, 0, 11, "outside left");
    query(224, 740, 750, 1'b0, 0, 0, 11, "edge 224");
    query(225, 740, 750, 1'b1, 0, 748, 11, "edge 225");
    query(767, 740, 750, 1'b1, 0, 748, 11, "edge 767");
    query(768, 740, 750, 1'b0, 0, 0, 11, "edge 768");
    query(4095, 740, 750, 1'b0, 0, 0, 11, "wrap 4095");
    query(300, 750, 740, 1'b0, 0, 0, 11, "upward");
    query(400, 0, 760, 1'b1, 9, 1, 2, "fall through all");

    // Start pulsed during SCAN and during DONE must be ignored.
    @(posedge clk);
    #2;
    player_x = 12'd300; feet_y_cur = 12'd740; feet_y_nxt = 12'd750; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    player_x = 12'd500; feet_y_cur = 12'd582; feet_y_nxt = 12'd582; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check("reentry first done", n, 1);
    check("reentry plat_idx", {28'd0, plat_idx}, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    count_dones(15, n);
    check("reentry extra dones", n, 0);
    check("start in DONE busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a scan.
    query(300, 660, 670, 1'b1, 1, 665, 10, "pre-reset");
    @(posedge clk);
    #2;
    player_x = 12'd300; feet_y_cur = 12'd740; feet_y_nxt = 12'd750; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort result", {busy, done, hit, plat_idx, land_y}, 32'd0);
    count_dones(15, n);
    check("abort no done", n, 0);
    query(225, 740, 750, 1'b1, 0, 748, 11, "post-reset");

    // Randomized queries against the reference.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) px = int'($urandom_range(0, 4095));
      else px = int'($urandom_range(150, 850));
      if ($urandom_range(0, 4) == 0) begin
        cur = int'($urandom_range(0, 4095));
        nxt = int'($urandom_range(0, 4095));
      end else begin
        top = 748 - 83 * int'($urandom_range(0, 9));
        cur = top - int'($urandom_range(0, 12));
        nxt = cur + int'($urandom_range(0, 25)) - 5;
        if (cur < 0) cur = 0;
        if (nxt < 0) nxt = 0;
      end
      r = compute_ref(px, cur, nxt);
      query(px, cur, nxt, r.hit, r.idx, r.land, r.lat, "random");
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
